// File: rtl/des_bus_master.sv
// des_bus_master
//   Host-side initiator for the 32-bit DES wrapper bus. Accepts a 64-bit key
//   and plaintext, loads them into the wrapper as four 32-bit halves, pulses
//   start, waits for a fresh ready edge (low then high), then reads the 64-bit
//   result back in two halves through result_sel.
//
// Parameters
//   READ_WAIT : extra cycles result_sel is held before result_out is sampled (>=1)
//   TIMEOUT   : max cycles spent waiting for ready before aborting with err
//
// Ports
//   clk, rst             : clock (rising edge), asynchronous active-high reset
//   req                  : operation request, only sampled while idle
//   key_in, text_in      : 64-bit key / plaintext, latched on acceptance
//   busy, done, err      : status; done/err are single-cycle pulses
//   result               : 64-bit ciphertext, valid from done until next acceptance
//   data_bus, selector,
//   load, start,
//   result_sel           : wrapper-side command outputs
//   result_out, ready    : wrapper-side responses
//
// Optional feature (macro DES_MASTER_CHECK_EN)
//   exp_in : expected result, latched with key/text
//   match  : 1 when result equals exp_in and no timeout occurred, set at done

module des_bus_master #(
    parameter int unsigned READ_WAIT = 1,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [63:0] key_in,
    input  logic [63:0] text_in,
`ifdef DES_MASTER_CHECK_EN
    input  logic [63:0] exp_in,
    output logic        match,
`endif
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [63:0] result,
    output logic [31:0] data_bus,
    output logic [1:0]  selector,
    output logic        load,
    output logic        start,
    output logic        result_sel,
    input  logic [31:0] result_out,
    input  logic        ready
);

    localparam int unsigned CMAX = (TIMEOUT > READ_WAIT + 1) ? TIMEOUT : READ_WAIT + 1;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_KL,
        S_LD_KH,
        S_LD_DL,
        S_LD_DH,
        S_START,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_RD_HI,
        S_RD_LO,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [63:0]   key_q;
    logic [63:0]   text_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic [63:0]   result_q;
    logic [31:0]   data_q;
    logic [1:0]    sel_q;
    logic          load_q;
    logic          start_q;
    logic          rsel_q;
`ifdef DES_MASTER_CHECK_EN
    logic [63:0]   exp_q;
    logic          match_q;
`endif

    // Shared counter: wait-time budget in the WAIT states, read hold in RD states.
    assign cnt_d = cnt_q + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            key_q    <= '0;
            text_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            data_q   <= '0;
            sel_q    <= '0;
            load_q   <= 1'b0;
            start_q  <= 1'b0;
            rsel_q   <= 1'b0;
`ifdef DES_MASTER_CHECK_EN
            exp_q    <= '0;
            match_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    rsel_q <= 1'b0;
                    if (req) begin
                        key_q    <= key_in;
                        text_q   <= text_in;
                        result_q <= '0;
                        busy_q   <= 1'b1;
                        load_q   <= 1'b1;
                        sel_q    <= 2'b00;
                        data_q   <= key_in[31:0];
                        state_q  <= S_LD_KL;
`ifdef DES_MASTER_CHECK_EN
                        exp_q    <= exp_in;
                        match_q  <= 1'b0;
`endif
                    end
                end
                // Outputs are registered, so each LD state programs the
                // selector/data pair that the following state presents.
                S_LD_KL: begin
                    sel_q   <= 2'b01;
                    data_q  <= key_q[63:32];
                    state_q <= S_LD_KH;
                end
                S_LD_KH: begin
                    sel_q   <= 2'b10;
                    data_q  <= text_q[31:0];
                    state_q <= S_LD_DL;
                end
                S_LD_DL: begin
                    sel_q   <= 2'b11;
                    data_q  <= text_q[63:32];
                    state_q <= S_LD_DH;
                end
                S_LD_DH: begin
                    load_q  <= 1'b0;
                    start_q <= 1'b1;
                    sel_q   <= '0;
                    data_q  <= '0;
                    state_q <= S_START;
                end
                S_START: begin
                    start_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_WAIT_LOW;
                end
                // Ready may still be high from the previous operation; only a
                // low-then-high sequence counts as completion.
                S_WAIT_LOW: begin
                    cnt_q <= cnt_d;
                    if (cnt_d >= CW'(TIMEOUT)) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                        result_q <= '0;
                    end else if (!ready) begin
                        state_q <= S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    cnt_q <= cnt_d;
                    if (ready) begin
                        cnt_q   <= '0;
                        rsel_q  <= 1'b0;
                        state_q <= S_RD_HI;
                    end else if (cnt_d >= CW'(TIMEOUT)) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                        result_q <= '0;
                    end
                end
                S_RD_HI: begin
                    if (cnt_q == CW'(READ_WAIT)) begin
                        result_q[63:32] <= result_out;
                        cnt_q           <= '0;
                        rsel_q          <= 1'b1;
                        state_q         <= S_RD_LO;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RD_LO: begin
                    if (cnt_q == CW'(READ_WAIT)) begin
                        result_q[31:0] <= result_out;
                        cnt_q          <= '0;
                        rsel_q         <= 1'b0;
                        done_q         <= 1'b1;
                        state_q        <= S_DONE;
`ifdef DES_MASTER_CHECK_EN
                        match_q <= ({result_q[63:32], result_out} == exp_q);
`endif
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign result     = result_q;
    assign data_bus   = data_q;
    assign selector   = sel_q;
    assign load       = load_q;
    assign start      = start_q;
    assign result_sel = rsel_q;
`ifdef DES_MASTER_CHECK_EN
    assign match      = match_q;
`endif

endmodule

// File: tb/tb_des_bus_master.sv
// Testbench for des_bus_master: drives directed and randomized operations
// against a small behavioural wrapper stub and checks status, latency, bus
// traffic and results against expectations derived from the operation inputs.

module tb_des_bus_master;

    localparam int unsigned RW = 2;
    localparam int unsigned TO = 24;

    localparam logic [63:0] FIPS_K = 64'h133457799bbcdff1;
    localparam logic [63:0] FIPS_T = 64'h0123456789abcdef;
    localparam logic [63:0] FIPS_R = 64'h85e813540f0ab405;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [63:0] key_in;
    logic [63:0] text_in;
    logic [63:0] exp_in;
    logic        match;
    logic        busy, done, err;
    logic [63:0] result;
    logic [31:0] data_bus;
    logic [1:0]  selector;
    logic        load, start, result_sel;
    logic [31:0] result_out;
    logic        ready;

    int vectors = 0;
    int miscompares = 0;

    des_bus_master #(.READ_WAIT(RW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .key_in     (key_in),
        .text_in    (text_in),
`ifdef DES_MASTER_CHECK_EN
        .exp_in     (exp_in),
        .match      (match),
`endif
        .busy       (busy),
        .done       (done),
        .err        (err),
        .result     (result),
        .data_bus   (data_bus),
        .selector   (selector),
        .load       (load),
        .start      (start),
        .result_sel (result_sel),
        .result_out (result_out),
        .ready      (ready)
    );

`ifndef DES_MASTER_CHECK_EN
    assign match = 1'b0;
`endif

    always #5 clk = ~clk;

    // Stand-in cipher: the real vector for FIPS inputs, a simple mix otherwise.
    function automatic logic [63:0] ref_cipher(input logic [63:0] k, input logic [63:0] t);
        if (k == FIPS_K && t == FIPS_T) return FIPS_R;
        return {k[31:0] ^ t[63:32], k[63:32] + t[31:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- wrapper stub ----------------
    int          stale_n = 0;
    int          delay_n = 4;
    int          wk = 0;
    logic [31:0] cap [4];
    logic [63:0] wres = '0;

    initial begin
        ready      = 1'b1;
        result_out = '0;
    end

    // ready during the k-th cycle after start: high for k<=stale, low until
    // k>delay, then high. result_out follows result_sel with one cycle lag.
    always @(posedge clk) begin
        if (load) cap[selector] <= data_bus;
        result_out <= result_sel ? wres[31:0] : wres[63:32];
        if (start) begin
            wres  <= ref_cipher({cap[1], cap[0]}, {cap[3], cap[2]});
            wk    <= 1;
            ready <= (1 <= stale_n) || (1 > delay_n);
        end else if (wk != 0) begin
            wk    <= wk + 1;
            ready <= (wk + 1 <= stale_n) || (wk + 1 > delay_n);
        end
    end

    // ---------------- bus monitor ----------------
    logic [33:0] ld_q[$];
    int n_starts = 0;
    int start_bad = 0;
    int rsel_cnt = 0;
    int n_done = 0;

    always @(negedge clk) begin
        if (load) ld_q.push_back({selector, data_bus});
        if (start) begin
            n_starts++;
            if (selector != 2'b00 || data_bus != 32'h0 || load) start_bad++;
        end
        if (result_sel) rsel_cnt++;
        if (done) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation; called and returns at #1 after a clock edge.
    task automatic run_op(input logic [63:0] k, input logic [63:0] t, input logic [63:0] ev,
                          input int dly, input int stl, input bit hold_req, input bit inject);
        logic [63:0] exp_res;
        logic [33:0] exp_ld [4];
        bit          to;
        int          lat;
        int          exp_lat;
        delay_n = dly;
        stale_n = stl;
        key_in  = k;
        text_in = t;
        exp_in  = ev;
        ld_q.delete();
        n_starts  = 0;
        start_bad = 0;
        rsel_cnt  = 0;
        n_done    = 0;
        to      = (dly + 1 > int'(TO));
        exp_res = to ? 64'h0 : ref_cipher(k, t);
        exp_lat = to ? 5 + int'(TO) : 5 + dly + 1 + 2 * int'(RW + 1);
        req = 1'b1;
        tick();
        if (!hold_req) req = 1'b0;
        check_eq("busy_rise", busy, 1);
        key_in  = {$urandom, $urandom};
        text_in = {$urandom, $urandom};
        lat = 0;
        while (lat < 300) begin
            if (inject && lat == 8) req = 1'b1;
            if (inject && lat == 9) req = 1'b0;
            tick();
            lat++;
            if (done) break;
        end
        check_eq("done_seen", done, 1);
        check_eq("latency", lat, exp_lat);
        check_eq("err", err, to);
        check_eq("result", result, exp_res);
        check_eq("busy_in_done", busy, 1);
`ifdef DES_MASTER_CHECK_EN
        check_eq("match", match, (!to && ev == exp_res));
`endif
        exp_ld[0] = {2'b00, k[31:0]};
        exp_ld[1] = {2'b01, k[63:32]};
        exp_ld[2] = {2'b10, t[31:0]};
        exp_ld[3] = {2'b11, t[63:32]};
        check_eq("load_count", ld_q.size(), 4);
        for (int i = 0; i < 4 && i < ld_q.size(); i++) check_eq("load_word", ld_q[i], exp_ld[i]);
        check_eq("start_count", n_starts, 1);
        check_eq("start_bus_idle", start_bad, 0);
        check_eq("rsel_hold", rsel_cnt, to ? 0 : int'(RW + 1));
        tick();
        check_eq("done_pulse", done, 0);
        check_eq("err_pulse", err, 0);
        check_eq("busy_fall", busy, 0);
        check_eq("result_held", result, exp_res);
        check_eq("done_count", n_done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] k, t, ev;
        int dly, stl;
        rst = 1'b1; req = 1'b0; key_in = '0; text_in = '0; exp_in = '0;
        repeat (2) tick();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_data", data_bus, 0);
        check_eq("rst_sel", selector, 0);
        check_eq("rst_load", load, 0);
        check_eq("rst_start", start, 0);
        check_eq("rst_rsel", result_sel, 0);
        check_eq("rst_match", match, 0);
        rst = 1'b0;
        tick();

        // FIPS vector
        run_op(FIPS_K, FIPS_T, FIPS_R, 5, 0, 0, 0);
        repeat (2) tick();

        // stale ready held 3 cycles after start
        run_op({$urandom, $urandom}, {$urandom, $urandom}, 64'h0, 7, 3, 0, 0);
        tick();

        // ready never rises: timeout from WAIT_HIGH
        run_op({$urandom, $urandom}, {$urandom, $urandom}, 64'h0, 1000, 0, 0, 0);
        tick();

        // ready stuck high: timeout from WAIT_LOW
        run_op({$urandom, $urandom}, {$urandom, $urandom}, 64'h0, 2000, 1000, 0, 0);
        tick();

        // req pulsed while waiting must be ignored
        run_op(FIPS_K, FIPS_T, FIPS_R, 8, 0, 0, 1);
        repeat (5) tick();
        check_eq("no_second_op", busy, 0);
        check_eq("no_second_done", n_done, 1);

        // reset during LD_DL
        key_in = FIPS_K; text_in = FIPS_T; n_done = 0;
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (2) tick();
        check_eq("ld_dl_sel", selector, 2'b10);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_load", load, 0);
        check_eq("rst_mid_start", start, 0);
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_sel", selector, 0);
        tick();
        rst = 1'b0;
        repeat (6) tick();
        check_eq("rst_mid_no_done", n_done, 0);
        run_op(FIPS_K, FIPS_T, FIPS_R, 3, 0, 0, 0);

        // back-to-back with req held high
        run_op({$urandom, $urandom}, {$urandom, $urandom}, 64'h0, 4, 1, 1, 0);
        run_op(FIPS_K, FIPS_T, FIPS_R, 6, 2, 1, 0);
        req = 1'b0;
        tick();

        // randomized operations
        for (int n = 0; n < 12; n++) begin
            k   = {$urandom, $urandom};
            t   = {$urandom, $urandom};
            dly = $urandom_range(10, 1);
            stl = (dly > 1) ? $urandom_range((dly - 1 > 3) ? 3 : dly - 1, 0) : 0;
            ev  = $urandom_range(1, 0) ? ref_cipher(k, t) : {$urandom, $urandom};
            run_op(k, t, ev, dly, stl, 0, 0);
            repeat ($urandom_range(2, 0)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
